// File: rtl/ctrl_stim_pkg.sv
// Shared types, default constants and golden-result functions for the control-statement stimulus sequencer.
package ctrl_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FINISH = 3'd4
  } stim_state_e;

  localparam logic [15:0] DEF_HOLD_CYCLES       = 16'd256;
  localparam logic [7:0]  DEF_SWEEP_LAST        = 8'hFF;
  localparam logic [7:0]  DEF_IF_ELSE_MAX_COUNT = 8'hF0;

  // The if/else branch only passes the counter through when it equals the match value.
  function automatic logic [7:0] exp_if(input logic [7:0] v, input logic [7:0] max_count);
    return (v == max_count) ? v : 8'h00;
  endfunction

  function automatic logic [7:0] exp_case(input logic [7:0] v);
    return (v <= 8'd9) ? (8'd10 - v) : 8'h00;
  endfunction

endpackage

// File: rtl/ctrl_stim_sequencer_if.sv
// Host/downstream-facing signal bundle of the stimulus sequencer.
// master = sequencer side, slave = host plus downstream block side.
interface ctrl_stim_sequencer_if;

  logic       START;
  logic       BUSY;
  logic       DONE;
  logic [7:0] IF_ELSE_COUNTER_1;
  logic [7:0] CASE_COUNTER_2;
  logic [7:0] WHILE_COUNTER_3;
  logic [7:0] FOR_LOOP_COUNTER_4;
  logic [7:0] REPEAT_LOOP_COUNTER_5;
  logic [7:0] IF_ELSE_RESULT_1;
  logic [7:0] CASE_RESULT_2;
  logic [7:0] ERR_COUNT;
  logic [7:0] FIRST_ERR_VALUE;
  logic       ERR;

  modport master (
    input  START, IF_ELSE_RESULT_1, CASE_RESULT_2,
    output BUSY, DONE, IF_ELSE_COUNTER_1, CASE_COUNTER_2, WHILE_COUNTER_3,
           FOR_LOOP_COUNTER_4, REPEAT_LOOP_COUNTER_5, ERR_COUNT, FIRST_ERR_VALUE, ERR
  );

  modport slave (
    output START, IF_ELSE_RESULT_1, CASE_RESULT_2,
    input  BUSY, DONE, IF_ELSE_COUNTER_1, CASE_COUNTER_2, WHILE_COUNTER_3,
           FOR_LOOP_COUNTER_4, REPEAT_LOOP_COUNTER_5, ERR_COUNT, FIRST_ERR_VALUE, ERR
  );

endinterface

// File: rtl/ctrl_stim_checker.sv
// Compares downstream results with golden values on each SAMPLE cycle; keeps a saturating
// mismatch count, the sweep value of the first mismatch and a sticky error flag. Outputs are registered.
module ctrl_stim_checker
  import ctrl_stim_pkg::*;
#(
  parameter logic [7:0] IF_ELSE_MAX_COUNT = DEF_IF_ELSE_MAX_COUNT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear_en,
  input  logic       sample_en,
  input  logic [7:0] v,
  input  logic [7:0] if_result,
  input  logic [7:0] case_result,
  output logic       err,
  output logic [7:0] err_count,
  output logic [7:0] first_err_value
);

  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] first_q, first_d;
  logic       mismatch;

  assign mismatch = (if_result != exp_if(v, IF_ELSE_MAX_COUNT)) ||
                    (case_result != exp_case(v));

  always_comb begin
    err_d   = err_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (clear_en) begin
      err_d   = 1'b0;
      cnt_d   = 8'h00;
      first_d = 8'h00;
    end else if (sample_en && mismatch) begin
      cnt_d = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + 8'd1);
      if (!err_q) begin
        first_d = v;
      end
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q   <= 1'b0;
      cnt_q   <= 8'h00;
      first_q <= 8'h00;
    end else begin
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign err             = err_q;
  assign err_count       = cnt_q;
  assign first_err_value = first_q;

endmodule

// File: rtl/ctrl_stim_sequencer.sv
// Sweeps one value onto all five downstream counter buses, holding each for HOLD_CYCLES (+1 sample) cycles.
// All outputs registered; result checking is compiled in only when CTRL_STIM_CHECK_EN is defined.
module ctrl_stim_sequencer
  import ctrl_stim_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES       = DEF_HOLD_CYCLES,
  parameter logic [7:0]  SWEEP_LAST        = DEF_SWEEP_LAST,
  parameter logic [7:0]  IF_ELSE_MAX_COUNT = DEF_IF_ELSE_MAX_COUNT
) (
  input  logic                 CLK,
  input  logic                 RST,
  ctrl_stim_sequencer_if.master sio
);

  stim_state_e state_q, state_d;
  logic [7:0]  v_q, v_d;
  logic [15:0] hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  stim_q, stim_d;
  logic        sample_en;
  logic        clear_en;

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    hold_d    = hold_q;
    sample_en = 1'b0;
    clear_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sio.START) begin
          clear_en = 1'b1;
          v_d      = 8'h00;
          state_d  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        hold_d  = 16'd0;
        state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (hold_q == (HOLD_CYCLES - 16'd1)) begin
          state_d = ST_SAMPLE;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if (v_q == SWEEP_LAST) begin
          state_d = ST_FINISH;
        end else begin
          v_d     = v_q + 8'd1;
          state_d = ST_FLUSH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state they describe.
    busy_d = (state_d == ST_FLUSH) || (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_FINISH);
    stim_d = ((state_d == ST_DRIVE) || (state_d == ST_SAMPLE)) ? v_d : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      v_q     <= 8'h00;
      hold_q  <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stim_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stim_q  <= stim_d;
    end
  end

  assign sio.BUSY                  = busy_q;
  assign sio.DONE                  = done_q;
  assign sio.IF_ELSE_COUNTER_1     = stim_q;
  assign sio.CASE_COUNTER_2        = stim_q;
  assign sio.WHILE_COUNTER_3       = stim_q;
  assign sio.FOR_LOOP_COUNTER_4    = stim_q;
  assign sio.REPEAT_LOOP_COUNTER_5 = stim_q;

`ifdef CTRL_STIM_CHECK_EN
  logic       chk_err;
  logic [7:0] chk_count;
  logic [7:0] chk_first;

  ctrl_stim_checker #(
    .IF_ELSE_MAX_COUNT(IF_ELSE_MAX_COUNT)
  ) u_checker (
    .CLK            (CLK),
    .RST            (RST),
    .clear_en       (clear_en),
    .sample_en      (sample_en),
    .v              (v_q),
    .if_result      (sio.IF_ELSE_RESULT_1),
    .case_result    (sio.CASE_RESULT_2),
    .err            (chk_err),
    .err_count      (chk_count),
    .first_err_value(chk_first)
  );

  assign sio.ERR             = chk_err;
  assign sio.ERR_COUNT       = chk_count;
  assign sio.FIRST_ERR_VALUE = chk_first;
`else
  logic unused_chk;
  assign unused_chk = ^{sio.IF_ELSE_RESULT_1, sio.CASE_RESULT_2, sample_en, clear_en};

  assign sio.ERR             = 1'b0;
  assign sio.ERR_COUNT       = 8'h00;
  assign sio.FIRST_ERR_VALUE = 8'h00;
`endif

endmodule
